manch_tx_ctrl: RTL and testbench

Frame sequencer in front of the Manchester encoder `man_mod`. It accepts a payload word from the tag logic and drives the encoder's enable and data inputs bit by bit, MSB first, at a programmable bit period. Each frame is a fixed preamble, then the payload, then an optional parity bit. It owns the encoder's `in_enable` and `in_data` and reports busy and done to the upstream controller.

---
 rtl/manch_pkg.sv | 6 +
 rtl/manch_bit_timer.sv | 16 +
 rtl/manch_tx_ctrl.sv | 83 ++++++++
 tb/tb_manch_tx_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/manch_pkg.sv
// manch_pkg: shared state encoding and default constants for the Manchester frame transmitter
package manch_pkg;
  typedef enum logic [2:0] {IDLE, PRE, PAY, PAR, END} tx_state_t;
  localparam logic [7:0] MANCH_PREAMBLE = 8'b1111_1110;
  localparam int MANCH_BIT_CLKS = 16;
endpackage

// File: rtl/manch_bit_timer.sv
// manch_bit_timer: bit-period divider, one-cycle bit_tick on the last clk of each bit
module manch_bit_timer #(
  parameter int BIT_CLKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = $clog2(BIT_CLKS);
  logic [CW-1:0] cnt;
  assign bit_tick = cnt == CW'(BIT_CLKS - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else cnt <= bit_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/manch_tx_ctrl.sv
// manch_tx_ctrl: preamble/payload/parity frame sequencer for man_mod; MANCH_TX_PARITY_EN adds an even-parity bit
module manch_tx_ctrl
  import manch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PRE_W = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(MANCH_PREAMBLE),
  parameter int BIT_CLKS = MANCH_BIT_CLKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              enc_enable,
  output logic              enc_data
);
  localparam int MX = PRE_W > DATA_W ? PRE_W : DATA_W;
  localparam int IW = MX > 1 ? $clog2(MX) : 1;
`ifdef MANCH_TX_PARITY_EN
  localparam tx_state_t POST_PAY = PAR;
`else
  localparam tx_state_t POST_PAY = END;
`endif
  tx_state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [DATA_W-1:0] sr, sr_nx;
  logic bit_tick, accept, active, par_bit;
  assign active = state == PRE || state == PAY || state == PAR;
  assign accept = state == IDLE && start && !abort;
  manch_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(accept || (active && abort)),
    .bit_tick(bit_tick)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sr <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      sr <= sr_nx;
    end
`ifdef MANCH_TX_PARITY_EN
  // parity is taken at latch time because the shift register is consumed during PAY
  logic par;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (accept) par <= ^data_in;
  assign par_bit = state == PAR && par;
`else
  assign par_bit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    sr_nx = sr;
    if (accept) begin
      state_nx = PRE;
      idx_nx = IW'(PRE_W - 1);
      sr_nx = data_in;
    end else if (active && abort) state_nx = IDLE;
    else if (state == END) state_nx = IDLE;
    else if (active && bit_tick) begin
      idx_nx = idx - 1'b1;
      sr_nx = state == PAY ? sr << 1 : sr;
      if (idx == '0) begin
        state_nx = state == PRE ? PAY : state == PAY ? POST_PAY : END;
        idx_nx = state == PRE ? IW'(DATA_W - 1) : '0;
      end
    end
  end
  assign busy = active;
  assign enc_enable = active;
  assign done = state == END;
  assign enc_data = state == PRE ? |(PREAMBLE & (PRE_W'(1) << idx)) :
                    state == PAY ? sr[DATA_W-1] : par_bit;
endmodule

// File: tb/tb_manch_tx_ctrl.sv
// tb_manch_tx_ctrl: table-driven frame bench with a per-cycle scoreboard of {busy,done,enc_enable,enc_data}
module tb_manch_tx_ctrl;
  import manch_pkg::*;
  localparam int BC = 16, PW = 8, DW = 16;
`ifdef MANCH_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = (PW + DW + P) * BC;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic busy, done, enc_enable, enc_data;
  int errs = 0, checks = 0;
  logic [3:0] q[$];
  typedef struct {
    logic [15:0] data;
    int abort_at;
    int s2_at;
    int rst_at;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  manch_tx_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .data_in(data_in),
    .busy(busy),
    .done(done),
    .enc_enable(enc_enable),
    .enc_data(enc_data)
  );

  function automatic logic [3:0] exp_at(logic [15:0] d, int c);
    int b;
    logic [7:0] pre;
    logic bitv;
    pre = 8'b1111_1110;
    if (c > FL) return (c == FL + 1) ? 4'b0100 : 4'b0000;
    b = (c - 1) / BC;
    if (b < PW) bitv = pre[PW-1-b];
    else if (b < PW + DW) bitv = d[DW-1-(b-PW)];
    else bitv = ^d;
    return {1'b1, 1'b0, 1'b1, bitv};
  endfunction

  task automatic check(string name, int c, logic [3:0] exp);
    logic [3:0] act;
    act = {busy, done, enc_enable, enc_data};
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: busy/done/en/data=%b expected %b", name, c, act, exp);
    end
  endtask

  task automatic run(int id, vec_t v);
    int stop, last, c;
    stop = v.abort_at > 0 ? v.abort_at : v.rst_at > 0 ? v.rst_at : 0;
    last = stop > 0 ? stop + 3 : FL + 2;
    for (int k = 1; k <= last; k++) q.push_back((stop == 0 || k <= stop) ? exp_at(v.data, k) : 4'b0000);
    start = 1'b1;
    data_in = v.data;
    c = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      c++;
      if (c == 1 || (v.s2_at > 0 && c == v.s2_at + 1)) start = 1'b0;
      if (v.abort_at > 0 && c == v.abort_at + 1) abort = 1'b0;
      if (v.rst_at > 0 && c == v.rst_at + 1) rst = 1'b0;
      check($sformatf("frame%0d", id), c, q.pop_front());
      if (c == v.s2_at) begin
        start = 1'b1;
        data_in = 16'hFFFF;
      end
      if (c == v.abort_at) abort = 1'b1;
      if (c == v.rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    tbl[0] = '{16'hA5C3, 0, 0, 0};
    tbl[1] = '{16'h0007, 0, 0, 0};
    tbl[2] = '{16'h1234, 0, 100, 0};
    tbl[3] = '{16'hBEEF, 150, 0, 0};
    tbl[4] = '{16'h5A5A, 0, 0, 0};
    tbl[5] = '{16'h8001, 0, 0, 200};
    tbl[6] = '{16'hFFFF, 0, 0, 0};
    tbl[7] = '{16'h0000, 0, 0, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      check("idle", i, 4'b0000);
    end
    // abort with start in the same cycle must not start a frame
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("start_abort", i, 4'b0000);
    end
    for (int i = 0; i < 8; i++) run(i, tbl[i]);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
